// File: rtl/exc_entry_ctrl.sv
// Exception entry/return sequencer driving regfile, CPSR/SPSR and PC strobes.
// Optional build macro EXC_PENDING_LATCH_EN makes und/swi requests sticky while busy.
module exc_entry_ctrl #(
  parameter logic [31:0] VEC_BASE   = 32'h0000_0000,
  parameter logic [31:0] IRQ_LR_OFS = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fiq_req,
  input  logic        irq_req,
  input  logic        und_req,
  input  logic        swi_req,
  input  logic        ret_req,
  input  logic [31:0] CPSR,
  input  logic [31:0] ret_pc,
  input  logic [31:0] lr_in,
  output logic [2:0]  Change_M,
  output logic        W_SPSR_s,
  output logic        Write_SPSR,
  output logic [2:0]  W_CPSR_s,
  output logic        Write_CPSR,
  output logic        Write_Reg,
  output logic [3:0]  W_Addr,
  output logic [31:0] W_Data,
  output logic        Write_PC,
  output logic [31:0] PC_New,
  output logic        busy,
  output logic [3:0]  ack
);

  // state   | meaning
  // S_IDLE  | arbitrate requests, grant one exception or a return
  // S_SAVE  | SPSR <= CPSR, LR <= return address
  // S_SWITCH| CPSR <= exception mode value
  // S_VECTOR| PC <= vector
  // S_RET   | CPSR <= SPSR, PC <= LR
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAVE   = 3'd1,
    S_SWITCH = 3'd2,
    S_VECTOR = 3'd3,
    S_RET    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    C_FIQ = 2'd0,
    C_IRQ = 2'd1,
    C_UND = 2'd2,
    C_SWI = 2'd3
  } cls_t;

  state_t state;
  cls_t   cls;

  logic   und_src, swi_src;
  logic   fiq_elig, irq_elig;
  logic   take;
  cls_t   take_cls;

  function automatic logic [2:0] mode_code(input cls_t c);
    case (c)
      C_FIQ:   mode_code = 3'd1;
      C_IRQ:   mode_code = 3'd2;
      C_SWI:   mode_code = 3'd3;
      default: mode_code = 3'd4;
    endcase
  endfunction

  function automatic logic [2:0] cpsr_sel(input cls_t c);
    case (c)
      C_FIQ:   cpsr_sel = 3'd3;
      C_IRQ:   cpsr_sel = 3'd2;
      C_SWI:   cpsr_sel = 3'd4;
      default: cpsr_sel = 3'd5;
    endcase
  endfunction

  function automatic logic [31:0] vec_ofs(input cls_t c);
    case (c)
      C_FIQ:   vec_ofs = 32'h1C;
      C_IRQ:   vec_ofs = 32'h18;
      C_SWI:   vec_ofs = 32'h08;
      default: vec_ofs = 32'h04;
    endcase
  endfunction

  function automatic logic [3:0] ack_bit(input cls_t c);
    case (c)
      C_FIQ:   ack_bit = 4'b1000;
      C_IRQ:   ack_bit = 4'b0100;
      C_UND:   ack_bit = 4'b0010;
      default: ack_bit = 4'b0001;
    endcase
  endfunction

`ifdef EXC_PENDING_LATCH_EN
  logic und_pend, swi_pend;
  logic grant;

  assign grant = (state == S_IDLE) && take;

  // Capture on any cycle; the granted bit is cleared by its own ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      und_pend <= 1'b0;
      swi_pend <= 1'b0;
    end else begin
      if (grant && take_cls == C_UND) und_pend <= 1'b0;
      else if (und_req)               und_pend <= 1'b1;
      if (grant && take_cls == C_SWI) swi_pend <= 1'b0;
      else if (swi_req)               swi_pend <= 1'b1;
    end
  end

  assign und_src = und_req | und_pend;
  assign swi_src = swi_req | swi_pend;
`else
  assign und_src = und_req;
  assign swi_src = swi_req;
`endif

  assign fiq_elig = fiq_req & ~CPSR[6];
  assign irq_elig = irq_req & ~CPSR[7];

  always_comb begin
    take     = 1'b1;
    take_cls = C_SWI;
    if (fiq_elig)      take_cls = C_FIQ;
    else if (irq_elig) take_cls = C_IRQ;
    else if (und_src)  take_cls = C_UND;
    else if (swi_src)  take_cls = C_SWI;
    else               take     = 1'b0;
  end

  // Outputs are loaded with the values belonging to the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cls        <= C_FIQ;
      Change_M   <= 3'd0;
      W_SPSR_s   <= 1'b0;
      Write_SPSR <= 1'b0;
      W_CPSR_s   <= 3'd0;
      Write_CPSR <= 1'b0;
      Write_Reg  <= 1'b0;
      W_Addr     <= 4'd0;
      W_Data     <= 32'd0;
      Write_PC   <= 1'b0;
      PC_New     <= 32'd0;
      busy       <= 1'b0;
      ack        <= 4'd0;
    end else begin
      Change_M   <= 3'd0;
      W_SPSR_s   <= 1'b0;
      Write_SPSR <= 1'b0;
      W_CPSR_s   <= 3'd0;
      Write_CPSR <= 1'b0;
      Write_Reg  <= 1'b0;
      W_Addr     <= 4'd0;
      W_Data     <= 32'd0;
      Write_PC   <= 1'b0;
      PC_New     <= 32'd0;
      busy       <= 1'b0;
      ack        <= 4'd0;
      case (state)
        S_IDLE: begin
          if (take) begin
            state      <= S_SAVE;
            cls        <= take_cls;
            ack        <= ack_bit(take_cls);
            Change_M   <= mode_code(take_cls);
            Write_SPSR <= 1'b1;
            W_SPSR_s   <= 1'b1;
            Write_Reg  <= 1'b1;
            W_Addr     <= 4'd14;
            W_Data     <= (take_cls == C_FIQ || take_cls == C_IRQ) ?
                          ret_pc + IRQ_LR_OFS : ret_pc;
            busy       <= 1'b1;
          end else if (ret_req) begin
            state      <= S_RET;
            Write_CPSR <= 1'b1;
            Write_PC   <= 1'b1;
            PC_New     <= lr_in;
            busy       <= 1'b1;
          end
        end
        S_SAVE: begin
          state      <= S_SWITCH;
          Change_M   <= mode_code(cls);
          Write_CPSR <= 1'b1;
          W_CPSR_s   <= cpsr_sel(cls);
          busy       <= 1'b1;
        end
        S_SWITCH: begin
          state    <= S_VECTOR;
          Write_PC <= 1'b1;
          PC_New   <= VEC_BASE + vec_ofs(cls);
          busy     <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_entry_ctrl.sv
// Directed self-checking bench for exc_entry_ctrl; compares the full output bundle each step.
module tb_exc_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fiq_req, irq_req, und_req, swi_req, ret_req;
  logic [31:0] CPSR, ret_pc, lr_in;
  logic [2:0]  Change_M;
  logic        W_SPSR_s, Write_SPSR;
  logic [2:0]  W_CPSR_s;
  logic        Write_CPSR, Write_Reg;
  logic [3:0]  W_Addr;
  logic [31:0] W_Data;
  logic        Write_PC;
  logic [31:0] PC_New;
  logic        busy;
  logic [3:0]  ack;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  exc_entry_ctrl dut (
    .clk(clk), .rst(rst),
    .fiq_req(fiq_req), .irq_req(irq_req), .und_req(und_req), .swi_req(swi_req),
    .ret_req(ret_req), .CPSR(CPSR), .ret_pc(ret_pc), .lr_in(lr_in),
    .Change_M(Change_M), .W_SPSR_s(W_SPSR_s), .Write_SPSR(Write_SPSR),
    .W_CPSR_s(W_CPSR_s), .Write_CPSR(Write_CPSR), .Write_Reg(Write_Reg),
    .W_Addr(W_Addr), .W_Data(W_Data), .Write_PC(Write_PC), .PC_New(PC_New),
    .busy(busy), .ack(ack)
  );

  // Bundle order: Change_M, W_SPSR_s, Write_SPSR, W_CPSR_s, Write_CPSR, Write_Reg,
  // W_Addr, W_Data, Write_PC, PC_New, busy, ack.
  function automatic logic [83:0] pack(
      input logic [2:0] cm, input logic ss, input logic ws, input logic [2:0] cs,
      input logic wc, input logic wr, input logic [3:0] wa, input logic [31:0] wd,
      input logic wp, input logic [31:0] pc, input logic b, input logic [3:0] a);
    pack = {cm, ss, ws, cs, wc, wr, wa, wd, wp, pc, b, a};
  endfunction

  function automatic logic [83:0] act();
    act = pack(Change_M, W_SPSR_s, Write_SPSR, W_CPSR_s, Write_CPSR, Write_Reg,
               W_Addr, W_Data, Write_PC, PC_New, busy, ack);
  endfunction

  function automatic logic [83:0] exp_save(input logic [2:0] m, input logic [31:0] d,
                                           input logic [3:0] a);
    exp_save = pack(m, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 4'd14, d, 1'b0, 32'd0, 1'b1, a);
  endfunction

  function automatic logic [83:0] exp_switch(input logic [2:0] m, input logic [2:0] s);
    exp_switch = pack(m, 1'b0, 1'b0, s, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd0);
  endfunction

  function automatic logic [83:0] exp_vector(input logic [31:0] pc);
    exp_vector = pack(3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, pc, 1'b1, 4'd0);
  endfunction

  function automatic logic [83:0] exp_ret(input logic [31:0] pc);
    exp_ret = pack(3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b1, pc, 1'b1, 4'd0);
  endfunction

  localparam logic [83:0] IDLE_OUT = 84'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fiq_req = 0; irq_req = 0; und_req = 0; swi_req = 0; ret_req = 0;
    CPSR = 32'h10; ret_pc = 32'd0; lr_in = 32'd0;
    tick(); tick();
    tests++;
    if (act() !== IDLE_OUT) begin
      fails++; $display("FAIL reset: got %h want %h", act(), IDLE_OUT);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (act() !== IDLE_OUT) begin
      fails++; $display("FAIL idle_after_reset: got %h want %h", act(), IDLE_OUT);
    end
  endtask

  task automatic test_swi();
    logic [83:0] e;
    swi_req = 1; CPSR = 32'h10; ret_pc = 32'h100;
    tick();
    swi_req = 0;
    e = exp_save(3'd3, 32'h100, 4'b0001);
    tests++;
    if (act() !== e) begin fails++; $display("FAIL swi_save: got %h want %h", act(), e); end
    tick();
    e = exp_switch(3'd3, 3'd4);
    tests++;
    if (act() !== e) begin fails++; $display("FAIL swi_switch: got %h want %h", act(), e); end
    tick();
    e = exp_vector(32'h08);
    tests++;
    if (act() !== e) begin fails++; $display("FAIL swi_vector: got %h want %h", act(), e); end
    tick();
    tests++;
    if (act() !== IDLE_OUT) begin fails++; $display("FAIL swi_idle: got %h want %h", act(), IDLE_OUT); end
  endtask

  task automatic test_fiq_irq_priority();
    logic [83:0] e;
    fiq_req = 1; irq_req = 1; CPSR = 32'h10; ret_pc = 32'h200;
    tick();
    fiq_req = 0;
    e = exp_save(3'd1, 32'h204, 4'b1000);
    tests++;
    if (act() !== e) begin fails++; $display("FAIL fiq_save: got %h want %h", act(), e); end
    tick();
    e = exp_switch(3'd1, 3'd3);
    tests++;
    if (act() !== e) begin fails++; $display("FAIL fiq_switch: got %h want %h", act(), e); end
    tick();
    e = exp_vector(32'h1C);
    tests++;
    if (act() !== e) begin fails++; $display("FAIL fiq_vector: got %h want %h", act(), e); end
    tick();
    tests++;
    if (act() !== IDLE_OUT) begin fails++; $display("FAIL fiq_idle: got %h want %h", act(), IDLE_OUT); end
    tick();
    irq_req = 0;
    e = exp_save(3'd2, 32'h204, 4'b0100);
    tests++;
    if (act() !== e) begin fails++; $display("FAIL irq_save: got %h want %h", act(), e); end
    tick();
    e = exp_switch(3'd2, 3'd2);
    tests++;
    if (act() !== e) begin fails++; $display("FAIL irq_switch: got %h want %h", act(), e); end
    tick();
    e = exp_vector(32'h18);
    tests++;
    if (act() !== e) begin fails++; $display("FAIL irq_vector: got %h want %h", act(), e); end
    tick();
  endtask

  task automatic test_masked_irq();
    logic [83:0] e;
    int bad;
    bad = 0;
    irq_req = 1; CPSR = 32'h90; ret_pc = 32'h400;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (act() !== IDLE_OUT) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL irq_masked: got %0d active cycles want 0", bad); end
    CPSR = 32'h10;
    tick();
    irq_req = 0;
    e = exp_save(3'd2, 32'h404, 4'b0100);
    tests++;
    if (act() !== e) begin fails++; $display("FAIL irq_unmask_save: got %h want %h", act(), e); end
    tick(); tick(); tick();
    tests++;
    if (act() !== IDLE_OUT) begin fails++; $display("FAIL irq_unmask_idle: got %h want %h", act(), IDLE_OUT); end
  endtask

  task automatic test_return();
    logic [83:0] e;
    ret_req = 1; lr_in = 32'h104;
    tick();
    ret_req = 0;
    e = exp_ret(32'h104);
    tests++;
    if (act() !== e) begin fails++; $display("FAIL ret: got %h want %h", act(), e); end
    tick();
    tests++;
    if (act() !== IDLE_OUT) begin fails++; $display("FAIL ret_idle: got %h want %h", act(), IDLE_OUT); end
    ret_req = 1; und_req = 1; ret_pc = 32'h300; lr_in = 32'h55C;
    tick();
    und_req = 0;
    e = exp_save(3'd4, 32'h300, 4'b0010);
    tests++;
    if (act() !== e) begin fails++; $display("FAIL und_over_ret_save: got %h want %h", act(), e); end
    tick();
    e = exp_switch(3'd4, 3'd5);
    tests++;
    if (act() !== e) begin fails++; $display("FAIL und_switch: got %h want %h", act(), e); end
    tick();
    e = exp_vector(32'h04);
    tests++;
    if (act() !== e) begin fails++; $display("FAIL und_vector: got %h want %h", act(), e); end
    tick();
    tick();
    ret_req = 0;
    e = exp_ret(32'h55C);
    tests++;
    if (act() !== e) begin fails++; $display("FAIL ret_after_und: got %h want %h", act(), e); end
    tick();
  endtask

  task automatic test_reset_mid_sequence();
    swi_req = 1; ret_pc = 32'h700;
    tick();
    swi_req = 0;
    tick();
    rst = 1;
    tick();
    tests++;
    if (act() !== IDLE_OUT) begin fails++; $display("FAIL rst_mid: got %h want %h", act(), IDLE_OUT); end
    rst = 0;
    tick();
    tests++;
    if (act() !== IDLE_OUT) begin fails++; $display("FAIL rst_no_vector: got %h want %h", act(), IDLE_OUT); end
  endtask

  task automatic test_und_pulse_while_busy();
    logic [83:0] e;
    irq_req = 1; CPSR = 32'h10; ret_pc = 32'h800;
    tick();
    irq_req = 0;
    und_req = 1;
    tick();
    und_req = 0;
    tick();
    tick();
    tests++;
    if (act() !== IDLE_OUT) begin fails++; $display("FAIL pulse_idle: got %h want %h", act(), IDLE_OUT); end
    tick();
`ifdef EXC_PENDING_LATCH_EN
    e = exp_save(3'd4, 32'h800, 4'b0010);
`else
    e = IDLE_OUT;
`endif
    tests++;
    if (act() !== e) begin fails++; $display("FAIL pulse_und: got %h want %h", act(), e); end
`ifdef EXC_PENDING_LATCH_EN
    tick();
    tick();
    e = exp_vector(32'h04);
    tests++;
    if (act() !== e) begin fails++; $display("FAIL pulse_und_vector: got %h want %h", act(), e); end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_swi();
    test_fiq_irq_priority();
    test_masked_irq();
    test_return();
    test_reset_mid_sequence();
    test_und_pulse_while_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exc_entry_ctrl.md
Name: exc_entry_ctrl

Overview:
Exception entry/return sequencer for the banked register file and the CPSR/SPSR block. It arbitrates FIQ, IRQ, undefined-instruction and SWI requests against the CPSR I/F masks. For each taken exception it drives a fixed multi-cycle sequence: SPSR save + LR write, mode switch, PC vector load. It also sequences exception return: restore CPSR from SPSR and load PC from LR. It sits beside the register file and CPSR block and owns their mode/select/write strobes during exception handling.

Parameters:
VEC_BASE, 32'h0000_0000, base address added to every vector offset
IRQ_LR_OFS, 32'd4, added to ret_pc when forming LR for IRQ/FIQ (SWI/UND use ret_pc unchanged)

Ports:
clk  in  1  system clock; FSM state updates on posedge
rst  in  1  synchronous active-high reset
fiq_req  in  1  FIQ request, level
irq_req  in  1  IRQ request, level
und_req  in  1  undefined-instruction request, level
swi_req  in  1  software-interrupt request, level
ret_req  in  1  exception-return request, level
CPSR  in  32  current CPSR; bit 7 = I mask, bit 6 = F mask
ret_pc  in  32  return address of interrupted/excepting instruction
lr_in  in  32  current-mode R14 value, used on return
Change_M  out  3  mode override to regfile/CPSR: 0 none, 1 fiq, 2 irq, 3 svc, 4 und
W_SPSR_s  out  1  1 = SPSR source is CPSR
Write_SPSR  out  1  SPSR write strobe
W_CPSR_s  out  3  CPSR source: 0 SPSR, 2 irq, 3 fiq, 4 svc, 5 und
Write_CPSR  out  1  CPSR write strobe
Write_Reg  out  1  register write strobe
W_Addr  out  4  register write address
W_Data  out  32  register write data
Write_PC  out  1  PC write strobe
PC_New  out  32  new PC value
busy  out  1  sequence in progress
ack  out  4  one-cycle grant pulse: [3] fiq, [2] irq, [1] und, [0] swi

Behaviour:
- All outputs are decoded from registered state and the latched exception class. They are stable for a whole cycle, and downstream negedge writes see settled values.
- Reset: state IDLE; every output 0; latched class cleared; pending bits cleared if the optional feature is enabled.
- Eligibility:
  - fiq eligible = fiq_req & ~CPSR[6]
  - irq eligible = irq_req & ~CPSR[7]
  - und and swi are never masked
- Priority: fiq > irq > und > swi. Any eligible exception beats ret_req in the same cycle; ret_req must be held until served.
- IDLE:
  - eligible exception -> SAVE; latch class and ret_pc; pulse the corresponding ack bit for this one cycle.
  - else ret_req -> RET.
  - busy = 0.
- SAVE (1 cycle):
  - Change_M = class code; Write_SPSR = 1; W_SPSR_s = 1.
  - Write_Reg = 1; W_Addr = 14.
  - W_Data = latched ret_pc + IRQ_LR_OFS for fiq/irq, latched ret_pc for und/swi (32-bit wrap).
  - -> SWITCH.
- SWITCH (1 cycle):
  - Change_M = class code; Write_CPSR = 1.
  - W_CPSR_s = 3 fiq, 2 irq, 5 und, 4 svc (swi).
  - -> VECTOR.
- VECTOR (1 cycle):
  - Change_M = 0; Write_PC = 1.
  - PC_New = VEC_BASE + offset: und 0x04, swi 0x08, irq 0x18, fiq 0x1C.
  - -> IDLE.
- RET (1 cycle):
  - Change_M = 0; Write_CPSR = 1; W_CPSR_s = 0.
  - Write_PC = 1; PC_New = lr_in sampled this cycle.
  - -> IDLE.
- busy = 1 in SAVE/SWITCH/VECTOR/RET.
- Total entry latency: 3 cycles after grant. Return latency: 1 cycle.
- Requests arriving while busy are not sampled; level requests still asserted are re-evaluated in the first IDLE cycle.
- A masked request stays unserved until its mask clears. No ack is given while masked.
- Unused strobe/select outputs are 0 in every state. W_Addr/W_Data are 0 outside SAVE.
- rst asserted mid-sequence: next posedge -> IDLE with all strobes 0. The partial sequence is abandoned, with no further writes.

Optional Feature:
EXC_PENDING_LATCH_EN:
- Defined: und_req and swi_req are captured into sticky pending bits on any cycle, including while busy. Arbitration uses pending | req. The winning bit clears on its ack. rst clears all pending bits. A one-cycle pulse during a sequence is served in order afterward.
- Undefined: und/swi are level-sampled in IDLE only; a pulse that falls entirely within busy is lost.

Test Plan:
- swi_req=1, CPSR=32'h10, ret_pc=32'h100 -> ack=0001. Then in order:
  - SAVE: Change_M=3, Write_SPSR=1, Write_Reg=1, W_Addr=14, W_Data=32'h100.
  - SWITCH: W_CPSR_s=4.
  - VECTOR: PC_New=32'h08.
  - Then IDLE.
- fiq_req=irq_req=1 same cycle, CPSR[7:6]=00, ret_pc=32'h200 -> fiq wins, ack=1000, W_Data=32'h204, W_CPSR_s=3, PC_New=32'h1C. irq is taken on the next IDLE cycle with PC_New=32'h18.
- irq_req=1 with CPSR[7]=1 for 10 cycles -> busy=0, no ack. Clear CPSR[7] -> IRQ entry begins next posedge.
- ret_req=1, lr_in=32'h104 -> one cycle with Write_CPSR=1, W_CPSR_s=0, Write_PC=1, PC_New=32'h104. ret_req and und_req together -> und wins.
- rst pulsed during SWITCH -> next cycle all outputs 0, busy=0, no VECTOR cycle.
- With EXC_PENDING_LATCH_EN: one-cycle und_req pulse during an IRQ sequence -> UND entry (PC_New=32'h04) directly after return to IDLE. Without the macro, the same pulse is ignored.
